rice_core_bus_arbiter: RTL and testbench

- Sits directly downstream of the core's instruction and data bus masters and merges them onto one shared memory bus.
- Arbitrates request handshakes and tracks outstanding transactions in order.
- Routes each response back to the master that issued the matching request.
- Lets the core run against a single-port memory or interconnect.

---
 rtl/rice_core_bus_arbiter_pkg.sv | 32 +++
 rtl/rice_core_bus_arbiter_if.sv | 32 +++
 rtl/rice_core_bus_arbiter_id_fifo.sv | 58 +++++
 rtl/rice_core_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_rice_core_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_bus_arbiter_pkg.sv
// Shared types and widths for the instruction/data bus arbiter.
// Contents: master ID enum, arbitration state enum, default widths,
// the request payload struct and a strobe-width helper.
package rice_core_bus_arbiter_pkg;

    localparam int unsigned RICE_ADDRESS_WIDTH = 32;
    localparam int unsigned RICE_DATA_WIDTH    = 32;
    localparam int unsigned RICE_STROBE_WIDTH  = RICE_DATA_WIDTH / 8;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } rice_bus_master_id_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rice_arb_state_e;

    // Payload presented on the shared bus while a request is pending.
    typedef struct packed {
        logic [RICE_ADDRESS_WIDTH-1:0] address;
        logic                          write;
        logic [RICE_DATA_WIDTH-1:0]    write_data;
        logic [RICE_STROBE_WIDTH-1:0]  strobe;
    } rice_bus_request_t;

    function automatic int unsigned strobe_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rice_core_bus_arbiter_if.sv
// One request/response bus channel (valid/ready request, valid/ready response).
// Modports:
//   master - issues requests, consumes responses
//   slave  - accepts requests, produces responses
interface rice_core_bus_arbiter_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned STROBE_WIDTH = DATA_WIDTH / 8;

    logic                     request_valid;
    logic                     request_ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [STROBE_WIDTH-1:0]  strobe;
    logic                     response_valid;
    logic                     response_ready;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     error;

    modport master (
        output request_valid, address, write, write_data, strobe, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, write, write_data, strobe, response_ready,
        output request_ready, response_valid, read_data, error
    );

endinterface

// File: rtl/rice_core_bus_arbiter_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered bus requests.
// Ports: clk, rst (sync, active high), push/push_id, pop, head, full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rice_core_bus_arbiter_id_fifo
    import rice_core_bus_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  rice_bus_master_id_e push_id,
    input  logic                pop,
    output rice_bus_master_id_e head,
    output logic                full,
    output logic                empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    rice_bus_master_id_e mem [DEPTH];

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_multi
            assign wr_idx = wr_ptr[IDX_W-1:0];
            assign rd_idx = rd_ptr[IDX_W-1:0];
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr - rd_ptr) == PTR_W'(DEPTH));
    assign head  = mem[rd_idx];

    // Pointer update; callers never push when full or pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // ID storage.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_id;
    end

endmodule

// File: rtl/rice_core_bus_arbiter.sv
// Merges the core's instruction and data masters onto one shared bus.
// Requests are muxed combinationally (zero added latency); each accepted
// request's master ID is queued so in-order responses route back correctly.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   inst     - instruction master channel (read only; write fields ignored)
//   data     - data master channel
//   bus      - shared downstream bus channel
// Build option: define RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN for fixed
// data-first priority; otherwise ties alternate round-robin.
module rice_core_bus_arbiter
    import rice_core_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH   = RICE_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH      = RICE_DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    rice_core_bus_arbiter_if.slave  inst,
    rice_core_bus_arbiter_if.slave  data,
    rice_core_bus_arbiter_if.master bus
);

    localparam int unsigned STROBE_WIDTH = strobe_width(DATA_WIDTH);

    rice_arb_state_e     state_q;
    rice_arb_state_e     state_d;
    rice_bus_master_id_e lock_q;
    rice_bus_master_id_e lock_d;
    rice_bus_master_id_e grant;
`ifndef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
    rice_bus_master_id_e last_grant_q;
    rice_bus_master_id_e last_grant_d;
`endif
    rice_bus_request_t   req;
    logic                grant_valid;
    logic                accept;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    rice_bus_master_id_e head;
    logic                unused_inst_payload;

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lock_q       <= INST;
`ifndef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
            last_grant_q <= DATA;
`endif
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
`ifndef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Grant selection, request mux and next state.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
`ifndef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        grant = INST;

        // A presented-but-stalled request keeps its grant so the payload is stable.
        if (state_q == LOCKED) begin
            grant = lock_q;
        end else if (inst.request_valid && data.request_valid) begin
`ifdef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
            grant = DATA;
`else
            grant = (last_grant_q == DATA) ? INST : DATA;
`endif
        end else if (data.request_valid) begin
            grant = DATA;
        end

        grant_valid = (grant == DATA) ? data.request_valid : inst.request_valid;

        if (grant == DATA) begin
            req = '{address:    RICE_ADDRESS_WIDTH'(data.address),
                    write:      data.write,
                    write_data: RICE_DATA_WIDTH'(data.write_data),
                    strobe:     RICE_STROBE_WIDTH'(data.strobe)};
        end else begin
            req = '{address:    RICE_ADDRESS_WIDTH'(inst.address),
                    write:      1'b0,
                    write_data: '0,
                    strobe:     '1};
        end

        bus.request_valid  = grant_valid && !fifo_full && !rst;
        accept             = bus.request_valid && bus.request_ready;
        inst.request_ready = (grant == INST) && !fifo_full && !rst && bus.request_ready;
        data.request_ready = (grant == DATA) && !fifo_full && !rst && bus.request_ready;

        bus.address    = ADDRESS_WIDTH'(req.address);
        bus.write      = req.write;
        bus.write_data = DATA_WIDTH'(req.write_data);
        bus.strobe     = STROBE_WIDTH'(req.strobe);

        if (accept) begin
            state_d = IDLE;
`ifndef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
            last_grant_d = grant;
`endif
        end else if (bus.request_valid) begin
            state_d = LOCKED;
            lock_d  = grant;
        end
    end

    rice_core_bus_arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Response routing by the oldest outstanding master ID.
    assign inst.response_valid = bus.response_valid && !fifo_empty && !rst && (head == INST);
    assign data.response_valid = bus.response_valid && !fifo_empty && !rst && (head == DATA);
    assign bus.response_ready  = !fifo_empty && !rst &&
                                 ((head == DATA) ? data.response_ready : inst.response_ready);
    assign pop                 = bus.response_valid && bus.response_ready;

    assign inst.read_data = bus.read_data;
    assign inst.error     = bus.error;
    assign data.read_data = bus.read_data;
    assign data.error     = bus.error;

    // The instruction master never writes; its write fields are don't-care.
    assign unused_inst_payload = ^{inst.write, inst.write_data, inst.strobe};

    // A response with nothing outstanding is a downstream protocol violation.
    no_response_when_empty: assert property (
        @(posedge clk) disable iff (rst) !(bus.response_valid && fifo_empty)
    );

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// Self-checking bench for rice_core_bus_arbiter: directed stimulus with a
// request scoreboard (bus address/write order) and a response scoreboard
// (routing, data, error), plus direct checks of ready/valid/payload.
module tb_rice_core_bus_arbiter;
    import rice_core_bus_arbiter_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXO = 2;
`ifdef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
    localparam rice_bus_master_id_e TIE_WINNER = DATA;
`else
    localparam rice_bus_master_id_e TIE_WINNER = INST;
`endif

    typedef struct {
        logic [AW-1:0] address;
        logic          write;
    } req_exp_t;

    typedef struct {
        rice_bus_master_id_e master;
        logic [DW-1:0]       rdata;
        logic                err;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];

    always #5 clk = ~clk;

    rice_core_bus_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) inst_if ();
    rice_core_bus_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) data_if ();
    rice_core_bus_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    rice_core_bus_arbiter #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .inst (inst_if),
        .data (data_if),
        .bus  (bus_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input rice_bus_master_id_e m);
        return (m == INST) ? inst_if.request_ready : data_if.request_ready;
    endfunction

    function automatic logic rsp_valid_of(input rice_bus_master_id_e m);
        return (m == INST) ? inst_if.response_valid : data_if.response_valid;
    endfunction

    function automatic logic [AW-1:0] addr_of(input rice_bus_master_id_e m);
        return (m == INST) ? inst_if.address : data_if.address;
    endfunction

    task automatic set_valid(input rice_bus_master_id_e m, input logic v);
        if (m == INST) inst_if.request_valid = v;
        else           data_if.request_valid = v;
    endtask

    // Drive one bus response for a cycle and expect it at master m.
    task automatic respond(input rice_bus_master_id_e m, input logic [DW-1:0] d, input logic e);
        rsp_q.push_back('{m, d, e});
        bus_if.response_valid = 1'b1;
        bus_if.read_data      = d;
        bus_if.error          = e;
        tick();
        bus_if.response_valid = 1'b0;
    endtask

    task automatic check_rsp(input rice_bus_master_id_e m, input logic [DW-1:0] d, input logic e);
        rsp_exp_t x;
        if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 64'(m), 64'(2'd2));
        end else begin
            x = rsp_q.pop_front();
            check("rsp_master", 64'(m), 64'(x.master));
            check("rsp_data", 64'(d), 64'(x.rdata));
            check("rsp_error", 64'(e), 64'(x.err));
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        req_exp_t r;
        if (!rst && bus_if.request_valid && bus_if.request_ready) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", 64'(bus_if.address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = req_q.pop_front();
                check("bus_address", 64'(bus_if.address), 64'(r.address));
                check("bus_write", 64'(bus_if.write), 64'(r.write));
            end
        end
        if (!rst && inst_if.response_valid && inst_if.response_ready)
            check_rsp(INST, inst_if.read_data, inst_if.error);
        if (!rst && data_if.response_valid && data_if.response_ready)
            check_rsp(DATA, data_if.read_data, data_if.error);
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rice_bus_master_id_e first;
        rice_bus_master_id_e second;

        rst = 1'b1;
        inst_if.request_valid = 1'b0; inst_if.address = '0;
        inst_if.write = 1'b1; inst_if.write_data = 32'hFFFF_FFFF; inst_if.strobe = 4'h0;
        inst_if.response_ready = 1'b0;
        data_if.request_valid = 1'b0; data_if.address = '0; data_if.write = 1'b0;
        data_if.write_data = '0; data_if.strobe = 4'h3; data_if.response_ready = 1'b0;
        bus_if.request_ready = 1'b0; bus_if.response_valid = 1'b0;
        bus_if.read_data = '0; bus_if.error = 1'b0;
        repeat (2) tick();

        // Outputs held quiet while reset is asserted.
        inst_if.request_valid = 1'b1; data_if.request_valid = 1'b1; bus_if.request_ready = 1'b1;
        #1;
        check("rst_bus_req_valid", 64'(bus_if.request_valid), 64'd0);
        check("rst_inst_req_ready", 64'(inst_if.request_ready), 64'd0);
        check("rst_data_req_ready", 64'(data_if.request_ready), 64'd0);
        check("rst_bus_rsp_ready", 64'(bus_if.response_ready), 64'd0);
        tick();
        rst = 1'b0;

        // Test 1: simultaneous requests, tie then the other master.
        first  = TIE_WINNER;
        second = (first == INST) ? DATA : INST;
        inst_if.address = 32'h100; data_if.address = 32'h200;
        req_q.push_back('{addr_of(first), 1'b0});
        req_q.push_back('{addr_of(second), 1'b0});
        #1;
        check("t1_c0_addr", 64'(bus_if.address), 64'(addr_of(first)));
        check("t1_c0_winner_ready", 64'(ready_of(first)), 64'd1);
        check("t1_c0_loser_ready", 64'(ready_of(second)), 64'd0);
        check("t1_c0_strobe", 64'(bus_if.strobe), (first == INST) ? 64'hF : 64'h3);
        tick();
        set_valid(first, 1'b0);
        #1;
        check("t1_c1_addr", 64'(bus_if.address), 64'(addr_of(second)));
        check("t1_c1_ready", 64'(ready_of(second)), 64'd1);
        tick();
        set_valid(second, 1'b0);
        inst_if.response_ready = 1'b1; data_if.response_ready = 1'b1;
        rsp_q.push_back('{first, 32'hAAAA, 1'b0});
        bus_if.response_valid = 1'b1; bus_if.read_data = 32'hAAAA; bus_if.error = 1'b0;
        #1;
        check("t1_r0_bus_rsp_ready", 64'(bus_if.response_ready), 64'd1);
        check("t1_r0_sel_valid", 64'(rsp_valid_of(first)), 64'd1);
        check("t1_r0_other_valid", 64'(rsp_valid_of(second)), 64'd0);
        tick();
        rsp_q.push_back('{second, 32'hBBBB, 1'b0});
        bus_if.read_data = 32'hBBBB;
        #1;
        check("t1_r1_sel_valid", 64'(rsp_valid_of(second)), 64'd1);
        check("t1_r1_other_valid", 64'(rsp_valid_of(first)), 64'd0);
        tick();
        bus_if.response_valid = 1'b0;

        // Test 2: stalled data request holds grant and payload while inst asserts.
        data_if.address = 32'h200; data_if.write = 1'b1; data_if.write_data = 32'hCAFE_0001;
        data_if.request_valid = 1'b1; bus_if.request_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) inst_if.request_valid = 1'b1;
            #1;
            check("t2_stall_valid", 64'(bus_if.request_valid), 64'd1);
            check("t2_stall_addr", 64'(bus_if.address), 64'h200);
            check("t2_stall_wdata", 64'(bus_if.write_data), 64'hCAFE_0001);
            check("t2_stall_inst_ready", 64'(inst_if.request_ready), 64'd0);
            tick();
        end
        bus_if.request_ready = 1'b1;
        req_q.push_back('{32'h200, 1'b1});
        req_q.push_back('{32'h100, 1'b0});
        #1;
        check("t2_data_accept_ready", 64'(data_if.request_ready), 64'd1);
        tick();
        data_if.request_valid = 1'b0;
        #1;
        check("t2_inst_addr", 64'(bus_if.address), 64'h100);
        check("t2_inst_ready", 64'(inst_if.request_ready), 64'd1);
        check("t2_inst_strobe", 64'(bus_if.strobe), 64'hF);
        tick();
        inst_if.request_valid = 1'b0;
        respond(DATA, 32'h1111, 1'b0);
        respond(INST, 32'h2222, 1'b0);

        // Test 3: third back-to-back request waits for a freed slot.
        data_if.write = 1'b0; data_if.address = 32'h300; data_if.request_valid = 1'b1;
        req_q.push_back('{32'h300, 1'b0});
        req_q.push_back('{32'h304, 1'b0});
        req_q.push_back('{32'h308, 1'b0});
        #1;
        check("t3_r0_ready", 64'(data_if.request_ready), 64'd1);
        tick();
        data_if.address = 32'h304;
        #1;
        check("t3_r1_ready", 64'(data_if.request_ready), 64'd1);
        tick();
        data_if.address = 32'h308;
        #1;
        check("t3_full_valid", 64'(bus_if.request_valid), 64'd0);
        check("t3_full_ready", 64'(data_if.request_ready), 64'd0);
        tick();
        rsp_q.push_back('{DATA, 32'h3333, 1'b0});
        bus_if.response_valid = 1'b1; bus_if.read_data = 32'h3333;
        #1;
        check("t3_pop_cycle_valid", 64'(bus_if.request_valid), 64'd0);
        check("t3_pop_cycle_ready", 64'(data_if.request_ready), 64'd0);
        tick();
        bus_if.response_valid = 1'b0;
        #1;
        check("t3_after_pop_ready", 64'(data_if.request_ready), 64'd1);
        tick();
        data_if.request_valid = 1'b0;
        respond(DATA, 32'h4444, 1'b0);
        respond(DATA, 32'h5555, 1'b0);

        // Test 4: response backpressure keeps the head; error propagates.
        data_if.address = 32'h400; data_if.request_valid = 1'b1;
        req_q.push_back('{32'h400, 1'b0});
        tick();
        data_if.request_valid = 1'b0;
        inst_if.address = 32'h480; inst_if.request_valid = 1'b1;
        req_q.push_back('{32'h480, 1'b0});
        tick();
        inst_if.request_valid = 1'b0;
        data_if.response_ready = 1'b0;
        bus_if.response_valid = 1'b1; bus_if.read_data = 32'h5A5A; bus_if.error = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_bp_bus_rsp_ready", 64'(bus_if.response_ready), 64'd0);
            check("t4_bp_data_valid", 64'(data_if.response_valid), 64'd1);
            check("t4_bp_inst_valid", 64'(inst_if.response_valid), 64'd0);
            check("t4_bp_data_error", 64'(data_if.error), 64'd1);
            tick();
        end
        data_if.response_ready = 1'b1;
        rsp_q.push_back('{DATA, 32'h5A5A, 1'b1});
        #1;
        check("t4_hs_bus_rsp_ready", 64'(bus_if.response_ready), 64'd1);
        tick();
        rsp_q.push_back('{INST, 32'h6B6B, 1'b0});
        bus_if.read_data = 32'h6B6B; bus_if.error = 1'b0;
        #1;
        check("t4_next_inst_valid", 64'(inst_if.response_valid), 64'd1);
        check("t4_next_data_valid", 64'(data_if.response_valid), 64'd0);
        tick();
        bus_if.response_valid = 1'b0;

        // Test 5: reset while locked with a request outstanding.
        inst_if.address = 32'h500; inst_if.request_valid = 1'b1;
        req_q.push_back('{32'h500, 1'b0});
        tick();
        inst_if.request_valid = 1'b0;
        data_if.address = 32'h600; data_if.request_valid = 1'b1; bus_if.request_ready = 1'b0;
        #1;
        check("t5_locked_valid", 64'(bus_if.request_valid), 64'd1);
        tick();
        rst = 1'b1; inst_if.request_valid = 1'b1;
        #1;
        check("t5_rst_bus_valid", 64'(bus_if.request_valid), 64'd0);
        tick();
        rst = 1'b0; bus_if.request_ready = 1'b1;
        first  = TIE_WINNER;
        second = (first == INST) ? DATA : INST;
        req_q.push_back('{addr_of(first), 1'b0});
        req_q.push_back('{addr_of(second), 1'b0});
        #1;
        check("t5_tie_addr", 64'(bus_if.address), 64'(addr_of(first)));
        check("t5_tie_ready", 64'(ready_of(first)), 64'd1);
        check("t5_rsp_inst_valid", 64'(inst_if.response_valid), 64'd0);
        check("t5_rsp_data_valid", 64'(data_if.response_valid), 64'd0);
        tick();
        set_valid(first, 1'b0);
        #1;
        check("t5_second_ready", 64'(ready_of(second)), 64'd1);
        tick();
        set_valid(second, 1'b0);
        respond(first, 32'h7777, 1'b0);
        respond(second, 32'h8888, 1'b0);

`ifdef RICE_CORE_BUS_ARBITER_DATA_PRIORITY_EN
        // Test 6: data wins every tie; inst waits until data drops.
        data_if.address = 32'h700; inst_if.address = 32'h780;
        data_if.request_valid = 1'b1; inst_if.request_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_q.push_back('{32'h700, 1'b0});
            if (i > 0) begin
                rsp_q.push_back('{DATA, DW'(i), 1'b0});
                bus_if.response_valid = 1'b1; bus_if.read_data = DW'(i);
            end
            #1;
            check("t6_data_addr", 64'(bus_if.address), 64'h700);
            check("t6_inst_ready", 64'(inst_if.request_ready), 64'd0);
            tick();
        end
        data_if.request_valid = 1'b0;
        req_q.push_back('{32'h780, 1'b0});
        rsp_q.push_back('{DATA, 32'h4, 1'b0});
        bus_if.response_valid = 1'b1; bus_if.read_data = 32'h4;
        #1;
        check("t6_inst_addr", 64'(bus_if.address), 64'h780);
        check("t6_inst_granted", 64'(inst_if.request_ready), 64'd1);
        tick();
        bus_if.response_valid = 1'b0;
        inst_if.request_valid = 1'b0;
        respond(INST, 32'h9999, 1'b0);
`endif

        repeat (3) tick();
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
